// File: rtl/data_fifo.sv
// data_fifo: valid/ready FIFO holding WIDTH-bit words ahead of the consuming
// datapath stage, with occupancy, almost-full and sticky overflow flags.
//
// Ports:
//   i_clk, i_rst (async, active-high), i_clear (sync flush)
//   i_push_valid / o_push_ready / i_push_data : producer side
//   o_pop_valid  / i_pop_ready  / o_pop_data  : consumer side
//   o_count, o_almost_full, o_overflow        : occupancy and status
module data_fifo #(
    parameter int WIDTH           = 10,
    parameter int DEPTH           = 4,
    parameter int AFULL_THRESHOLD = 3,
    localparam int CW             = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [CW-1:0]    o_count,
    output logic             o_almost_full,
    output logic             o_overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESHOLD);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          ovf_q,  ovf_d;

    logic push_ok;
    logic pop_ok;

    // Status outputs come straight from registered state only.
    assign o_push_ready  = (cnt_q != FULL_C);
    assign o_pop_valid   = (cnt_q != '0);
    assign o_count       = cnt_q;
    assign o_almost_full = (cnt_q >= AFULL_C);
    assign o_overflow    = ovf_q;
    assign o_pop_data    = mem_q[rptr_q];

    assign push_ok = i_push_valid && o_push_ready;
    assign pop_ok  = o_pop_valid && i_pop_ready;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (i_clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop_ok) begin
                rptr_d = ptr_inc(rptr_q);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (i_push_valid && !o_push_ready) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // A flush discards the pending push; stored words are left in place.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok && !i_clear) begin
            mem_q[wptr_q] <= i_push_data;
        end
    end

endmodule

// File: tb/tb_data_fifo.sv
// tb_data_fifo: drives a DEPTH=4 and a DEPTH=3 data_fifo with identical
// stimulus and compares both against queue-based reference models.
module tb_data_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       push_valid = 1'b0;
    logic [9:0] push_data = '0;
    logic       pop_ready = 1'b0;

    logic       rdy4, vld4, af4, ovf4;
    logic [9:0] dat4;
    logic [2:0] cnt4;
    logic       rdy3, vld3, af3, ovf3;
    logic [9:0] dat3;
    logic [1:0] cnt3;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] q4[$];
    logic [9:0] q3[$];
    bit         m_ovf4 = 1'b0;
    bit         m_ovf3 = 1'b0;

    always #5 clk = ~clk;

    data_fifo #(.WIDTH(10), .DEPTH(4), .AFULL_THRESHOLD(3)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_push_valid(push_valid), .o_push_ready(rdy4),
        .i_push_data(push_data),
        .o_pop_valid(vld4), .i_pop_ready(pop_ready), .o_pop_data(dat4),
        .o_count(cnt4), .o_almost_full(af4), .o_overflow(ovf4)
    );

    data_fifo #(.WIDTH(10), .DEPTH(3), .AFULL_THRESHOLD(2)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_push_valid(push_valid), .o_push_ready(rdy3),
        .i_push_data(push_data),
        .o_pop_valid(vld3), .i_pop_ready(pop_ready), .o_pop_data(dat3),
        .o_count(cnt3), .o_almost_full(af3), .o_overflow(ovf3)
    );

    function automatic logic [31:0] pack(input int c, input bit r, input bit v,
                                         input bit a, input bit o,
                                         input logic [9:0] d);
        return {8'(c), r, v, a, o, 2'b00, (v ? d : 10'h000), 8'h00};
    endfunction

    function automatic logic [31:0] obs4();
        return pack(int'(cnt4), rdy4, vld4, af4, ovf4, dat4);
    endfunction

    function automatic logic [31:0] obs3();
        return pack(int'(cnt3), rdy3, vld3, af3, ovf3, dat3);
    endfunction

    function automatic logic [31:0] exp4();
        logic [9:0] h;
        int n;
        n = q4.size();
        h = (n > 0) ? q4[0] : 10'h000;
        return pack(n, n != 4, n != 0, n >= 3, m_ovf4, h);
    endfunction

    function automatic logic [31:0] exp3();
        logic [9:0] h;
        int n;
        n = q3.size();
        h = (n > 0) ? q3[0] : 10'h000;
        return pack(n, n != 3, n != 0, n >= 2, m_ovf3, h);
    endfunction

    task automatic model_reset();
        q4.delete();
        q3.delete();
        m_ovf4 = 1'b0;
        m_ovf3 = 1'b0;
    endtask

    // One clock: inputs held across the edge, models advanced from the
    // pre-edge occupancy, inputs released 1 ns after the edge.
    task automatic step(input bit pv, input logic [9:0] pd,
                        input bit pr, input bit clr);
        bit push4, push3;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        clear      = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            push4 = pv && (q4.size() < 4);
            push3 = pv && (q3.size() < 3);
            if (pv && !push4) m_ovf4 = 1'b1;
            if (pv && !push3) m_ovf3 = 1'b1;
            if (pr && q4.size() > 0) void'(q4.pop_front());
            if (pr && q3.size() > 0) void'(q3.pop_front());
            if (push4) q4.push_back(pd);
            if (push3) q3.push_back(pd);
        end
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rv;
        rv = pack(0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'($urandom);
            push_data  = 10'($urandom);
            pop_ready  = 1'($urandom);
            clear      = 1'($urandom);
            @(posedge clk);
            #1;
            n_vec++;
            if (obs4() !== rv || dat4 !== 10'h000) begin
                n_err++;
                $display("FAIL reset d4: got %h/%h want %h/000",
                         obs4(), dat4, rv);
            end
            n_vec++;
            if (obs3() !== rv || dat3 !== 10'h000) begin
                n_err++;
                $display("FAIL reset d3: got %h/%h want %h/000",
                         obs3(), dat3, rv);
            end
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        clear      = 1'b0;
        rst        = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_drain();
        logic [9:0] w[4];
        w[0] = 10'h001;
        w[1] = 10'h002;
        w[2] = 10'h3FF;
        w[3] = 10'h155;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w[i], 1'b0, 1'b0);
            n_vec++;
            if (obs4() !== exp4()) begin
                n_err++;
                $display("FAIL fill d4 #%0d: got %h want %h", i, obs4(), exp4());
            end
            n_vec++;
            if (obs3() !== exp3()) begin
                n_err++;
                $display("FAIL fill d3 #%0d: got %h want %h", i, obs3(), exp3());
            end
        end
        n_vec++;
        if ({cnt4, rdy4, af4} !== {3'd4, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL full d4: cnt=%0d rdy=%b af=%b want 4/0/1",
                     cnt4, rdy4, af4);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (dat4 !== w[i] || vld4 !== 1'b1) begin
                n_err++;
                $display("FAIL drain d4 #%0d: got %h v=%b want %h",
                         i, dat4, vld4, w[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
            n_vec++;
            if (obs3() !== exp3()) begin
                n_err++;
                $display("FAIL drain d3 #%0d: got %h want %h", i, obs3(), exp3());
            end
        end
        n_vec++;
        if (cnt4 !== 3'd0 || vld4 !== 1'b0) begin
            n_err++;
            $display("FAIL drained d4: cnt=%0d v=%b want 0/0", cnt4, vld4);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'(i), 1'b0, 1'b0);
            n_vec++;
            if (dat3 !== 10'(i) || vld3 !== 1'b1 || cnt3 !== 2'd1) begin
                n_err++;
                $display("FAIL wrap d3 #%0d: got %h v=%b c=%0d want %h",
                         i, dat3, vld3, cnt3, 10'(i));
            end
            n_vec++;
            if (obs4() !== exp4()) begin
                n_err++;
                $display("FAIL wrap d4 #%0d: got %h want %h", i, obs4(), exp4());
            end
            step(1'b0, '0, 1'b1, 1'b0);
            n_vec++;
            if (cnt3 !== 2'd0 || vld3 !== 1'b0) begin
                n_err++;
                $display("FAIL wrap pop d3 #%0d: c=%0d v=%b want 0/0",
                         i, cnt3, vld3);
            end
        end
    endtask

    task automatic test_full_pop();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'($urandom), 1'b0, 1'b0);
        end
        step(1'b1, 10'h0AA, 1'b1, 1'b0);
        n_vec++;
        if ({cnt4, ovf4} !== {3'd3, 1'b1} || obs4() !== exp4()) begin
            n_err++;
            $display("FAIL full_pop d4: got %h want %h", obs4(), exp4());
        end
        step(1'b1, 10'h0AA, 1'b0, 1'b0);
        n_vec++;
        if (cnt4 !== 3'd4 || obs4() !== exp4()) begin
            n_err++;
            $display("FAIL retry d4: got %h want %h", obs4(), exp4());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_vec++;
            if (ovf4 !== 1'b1 || obs4() !== exp4()) begin
                n_err++;
                $display("FAIL sticky d4 #%0d: got %h want %h",
                         i, obs4(), exp4());
            end
        end
        step(1'b0, '0, 1'b0, 1'b1);
        n_vec++;
        if (ovf4 !== 1'b0 || ovf3 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf clear: got %b%b want 00", ovf4, ovf3);
        end
    endtask

    task automatic test_stream();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 10'($urandom), 1'b0, 1'b0);
        step(1'b1, 10'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (obs4() !== exp4()) begin
                n_err++;
                $display("FAIL stream d4 #%0d: got %h want %h",
                         i, obs4(), exp4());
            end
            n_vec++;
            if (obs3() !== exp3()) begin
                n_err++;
                $display("FAIL stream d3 #%0d: got %h want %h",
                         i, obs3(), exp3());
            end
            step(1'b1, 10'($urandom), 1'b1, 1'b0);
        end
        n_vec++;
        if (cnt4 !== 3'd2 || cnt3 !== 2'd2) begin
            n_err++;
            $display("FAIL stream cnt: got %0d/%0d want 2/2", cnt4, cnt3);
        end
    endtask

    task automatic test_clear_rst();
        logic [31:0] rv;
        rv = pack(0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'($urandom), 1'b0, 1'b0);
        end
        step(1'b1, 10'h0FF, 1'b0, 1'b0);
        step(1'b1, 10'h123, 1'b0, 1'b1);
        n_vec++;
        if ({cnt4, vld4, ovf4} !== {3'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL clear d4: cnt=%0d v=%b ovf=%b want 0/0/0",
                     cnt4, vld4, ovf4);
        end
        n_vec++;
        if (obs3() !== exp3()) begin
            n_err++;
            $display("FAIL clear d3: got %h want %h", obs3(), exp3());
        end
        step(1'b1, 10'h0AB, 1'b0, 1'b0);
        step(1'b1, 10'h0CD, 1'b1, 1'b0);
        push_valid = 1'b1;
        push_data  = 10'h0EF;
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs4() !== rv || dat4 !== 10'h000) begin
            n_err++;
            $display("FAIL async rst d4: got %h/%h want %h/000",
                     obs4(), dat4, rv);
        end
        n_vec++;
        if (obs3() !== rv || dat3 !== 10'h000) begin
            n_err++;
            $display("FAIL async rst d3: got %h/%h want %h/000",
                     obs3(), dat3, rv);
        end
        push_valid = 1'b0;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 10'($urandom), 1'($urandom),
                 ($urandom_range(15) == 0));
            n_vec++;
            if (obs4() !== exp4()) begin
                n_err++;
                $display("FAIL random d4 #%0d: got %h want %h",
                         i, obs4(), exp4());
            end
            n_vec++;
            if (obs3() !== exp3()) begin
                n_err++;
                $display("FAIL random d3 #%0d: got %h want %h",
                         i, obs3(), exp3());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_stream();
        test_clear_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
